crc_stream_engine: RTL and testbench

- Parametrised successor to the single-bit serial CCITT CRC block.
- Generic polynomial, width, init and xor-out values; consumes DATA_W bits per cycle.
- Frames input with a last marker and reports residue-check pass/fail.
- Can optionally append the computed CRC to an outgoing stream with backpressure.
- Used for both frame generation (TX) and frame checking (RX) in the link datapath.

---
 rtl/crc_stream_engine_if.sv | 31 +++
 rtl/crc_stream_engine.sv | 130 +++++++++++++
 tb/tb_crc_stream_engine.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_stream_engine_if.sv
// Stream bundle for crc_stream_engine: input beats, framing controls,
// CRC append stream with backpressure, and frame result reporting.
interface crc_stream_engine_if #(
    parameter int DATA_W = 1,
    parameter int CRC_W  = 16
) ();
    logic              init;
    logic              enable;
    logic [DATA_W-1:0] data_in;
    logic              last;
    logic              append;
    logic              in_ready;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_valid;
    logic              crc_match;

    // Producer / consumer side that feeds beats and drains the tx stream.
    modport master (
        output init, enable, data_in, last, append, tx_ready,
        input  in_ready, tx_valid, tx_data, crc_out, crc_valid, crc_match
    );

    // Engine side.
    modport slave (
        input  init, enable, data_in, last, append, tx_ready,
        output in_ready, tx_valid, tx_data, crc_out, crc_valid, crc_match
    );
endinterface

// File: rtl/crc_stream_engine.sv
// Parametrised CRC engine: absorbs DATA_W bits per beat (MSB first), reports
// the frame CRC and residue check, and optionally serialises the CRC onto a
// backpressured tx stream, most significant slice first.
module crc_stream_engine #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000,
    parameter int               DATA_W  = 1
) (
    input logic                 clk,
    input logic                 reset,
    crc_stream_engine_if.slave  bus
);

    localparam int N_SLICES = CRC_W / DATA_W;
    localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICES - 1);

    generate
        if (DATA_W < 1 || DATA_W > CRC_W || (CRC_W % DATA_W) != 0) begin : g_bad_data_w
            $error("crc_stream_engine: DATA_W must be in 1..CRC_W and divide CRC_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN,
        ST_APPEND,
        ST_DONE
    } state_t;

    state_t           state, state_next;
    logic [CRC_W-1:0] crc_reg, crc_next;
    logic [CRC_W-1:0] tx_shift, tx_shift_next;
    logic [CNT_W-1:0] slice_cnt, slice_cnt_next;
    logic [CRC_W-1:0] crc_beat;

    // DATA_W unrolled LFSR steps, bit DATA_W-1 of the beat first.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    assign crc_beat = crc_step(crc_reg, bus.data_in);

    // Next-state logic for the frame FSM, CRC register and tx serialiser.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next     = state;
        crc_next       = crc_reg;
        tx_shift_next  = tx_shift;
        slice_cnt_next = slice_cnt;

        if (bus.init) begin
            // Restart wins over everything, including a beat in the same cycle.
            state_next     = ST_RUN;
            crc_next       = INIT;
            slice_cnt_next = '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (bus.enable) begin
                        crc_next = crc_beat;
                        if (bus.last) begin
                            if (bus.append) begin
                                tx_shift_next  = crc_beat ^ XOR_OUT;
                                slice_cnt_next = '0;
                                state_next     = ST_APPEND;
                            end else begin
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                ST_APPEND: begin
                    if (bus.tx_ready) begin
                        tx_shift_next = tx_shift << DATA_W;
                        if (slice_cnt == LAST_SLICE) begin
                            slice_cnt_next = '0;
                            state_next     = ST_DONE;
                        end else begin
                            slice_cnt_next = slice_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    crc_next   = INIT;
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_RUN;
                    crc_next   = INIT;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            crc_reg   <= INIT;
            tx_shift  <= '0;
            slice_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state     <= state_next;
            crc_reg   <= crc_next;
            tx_shift  <= tx_shift_next;
            slice_cnt <= slice_cnt_next;
        end
    end

    // Outputs depend on state only, so a same-cycle init takes effect next cycle.
    assign bus.in_ready  = (state == ST_RUN);
    assign bus.tx_valid  = (state == ST_APPEND);
    assign bus.tx_data   = (state == ST_APPEND) ? tx_shift[CRC_W-1 -: DATA_W] : '0;
    assign bus.crc_out   = crc_reg ^ XOR_OUT;
    assign bus.crc_valid = (state == ST_DONE);
    assign bus.crc_match = (state == ST_DONE) && (crc_reg == RESIDUE);

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine at DATA_W = 1, 8 and 4 using
// scoreboards for frame results and appended CRC slices.
module tb_crc_stream_engine;

    logic clk;
    logic reset;

    crc_stream_engine_if #(.DATA_W(1), .CRC_W(16)) bus1 ();
    crc_stream_engine_if #(.DATA_W(8), .CRC_W(16)) bus8 ();
    crc_stream_engine_if #(.DATA_W(4), .CRC_W(16)) bus4 ();

    crc_stream_engine #(.DATA_W(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    crc_stream_engine #(.DATA_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
    crc_stream_engine #(.DATA_W(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct packed {
        logic [15:0] crc;
        logic        match;
    } crc_exp_t;

    crc_exp_t     sb1[$];
    crc_exp_t     sb8[$];
    crc_exp_t     sb4[$];
    logic [3:0]   sb_tx[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic       stall_prev = 1'b0;
    logic [3:0] held_data  = 4'h0;

    byte unsigned msg[$]      = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    byte unsigned msg_good[$];
    byte unsigned msg_bad[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Byte-wise reference CRC (CCITT, init FFFF, no reflection, no xor-out).
    function automatic logic [15:0] model_crc(input byte unsigned b[$]);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (b[k]) begin
            r = r ^ {b[k], 8'h00};
            for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // Frame-result scoreboards: pop one expectation per crc_valid pulse.
    always @(negedge clk) begin
        if (bus1.crc_valid) begin
            check("dw1_sb_pending", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0) begin
                check("dw1_crc_out", 32'(bus1.crc_out), 32'(sb1[0].crc));
                check("dw1_crc_match", 32'(bus1.crc_match), 32'(sb1[0].match));
                sb1.delete(0);
            end
        end
        if (bus8.crc_valid) begin
            check("dw8_sb_pending", 32'(sb8.size() != 0), 32'd1);
            if (sb8.size() != 0) begin
                check("dw8_crc_out", 32'(bus8.crc_out), 32'(sb8[0].crc));
                check("dw8_crc_match", 32'(bus8.crc_match), 32'(sb8[0].match));
                sb8.delete(0);
            end
        end
        if (bus4.crc_valid) begin
            check("dw4_sb_pending", 32'(sb4.size() != 0), 32'd1);
            if (sb4.size() != 0) begin
                check("dw4_crc_out", 32'(bus4.crc_out), 32'(sb4[0].crc));
                check("dw4_crc_match", 32'(bus4.crc_match), 32'(sb4[0].match));
                sb4.delete(0);
            end
        end
    end

    // Appended-slice scoreboard and stall stability for the DATA_W=4 engine.
    always @(negedge clk) begin
        if (bus4.tx_valid && stall_prev)
            check("dw4_tx_hold", 32'(bus4.tx_data), 32'(held_data));
        if (bus4.tx_valid && bus4.tx_ready) begin
            check("dw4_tx_pending", 32'(sb_tx.size() != 0), 32'd1);
            if (sb_tx.size() != 0) begin
                check("dw4_tx_slice", 32'(bus4.tx_data), 32'(sb_tx[0]));
                sb_tx.delete(0);
            end
        end
        stall_prev <= bus4.tx_valid && !bus4.tx_ready;
        held_data  <= bus4.tx_data;
    end

    task automatic frame1(input byte unsigned b[$], input logic [15:0] exp_crc);
        for (int k = 0; k < b.size(); k++) begin
            for (int i = 7; i >= 0; i--) begin
                @(posedge clk); #2;
                bus1.enable  = 1'b1;
                bus1.data_in = b[k][i];
                bus1.last    = (k == b.size() - 1) && (i == 0);
            end
        end
        sb1.push_back({exp_crc, 1'b0});
        @(posedge clk); #2;
        bus1.enable = 1'b0;
        bus1.last   = 1'b0;
        @(negedge clk);
        check("dw1_valid_latency", 32'(bus1.crc_valid), 32'd1);
        check("dw1_done_in_ready", 32'(bus1.in_ready), 32'd0);
        @(negedge clk);
        check("dw1_valid_pulse", 32'(bus1.crc_valid), 32'd0);
    endtask

    task automatic frame8(input byte unsigned b[$], input logic [15:0] exp_crc,
                          input logic exp_match);
        for (int k = 0; k < b.size(); k++) begin
            @(posedge clk); #2;
            bus8.enable  = 1'b1;
            bus8.data_in = b[k];
            bus8.last    = (k == b.size() - 1);
        end
        sb8.push_back({exp_crc, exp_match});
        @(posedge clk); #2;
        bus8.enable = 1'b0;
        bus8.last   = 1'b0;
        @(negedge clk);
        check("dw8_valid_latency", 32'(bus8.crc_valid), 32'd1);
        @(negedge clk);
        check("dw8_valid_pulse", 32'(bus8.crc_valid), 32'd0);
    endtask

    // Drives every nibble of b; the last beat is left on the bus for the caller.
    task automatic frame4_beats(input byte unsigned b[$], input logic app);
        for (int k = 0; k < b.size(); k++) begin
            for (int h = 1; h >= 0; h--) begin
                @(posedge clk); #2;
                bus4.enable  = 1'b1;
                bus4.data_in = (h == 1) ? b[k][7:4] : b[k][3:0];
                bus4.last    = (k == b.size() - 1) && (h == 0);
                bus4.append  = app;
            end
        end
    endtask

    task automatic end_beat4();
        @(posedge clk); #2;
        bus4.enable = 1'b0;
        bus4.last   = 1'b0;
        bus4.append = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        msg_good = {msg, 8'h29, 8'hB1};
        msg_bad  = {msg, 8'h29, 8'hB0};
        bus1.init = 0; bus1.enable = 0; bus1.data_in = '0; bus1.last = 0; bus1.append = 0; bus1.tx_ready = 1;
        bus8.init = 0; bus8.enable = 0; bus8.data_in = '0; bus8.last = 0; bus8.append = 0; bus8.tx_ready = 1;
        bus4.init = 0; bus4.enable = 0; bus4.data_in = '0; bus4.last = 0; bus4.append = 0; bus4.tx_ready = 1;
        reset = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        check("rst_tx_valid", 32'(bus4.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus4.tx_data), 32'd0);
        check("rst_crc_valid", 32'(bus4.crc_valid), 32'd0);
        check("rst_crc_match", 32'(bus4.crc_match), 32'd0);
        check("rst_crc_out", 32'(bus1.crc_out), 32'hFFFF);
        #10 reset = 1'b1;

        // Serial and byte-wide check values, then residue pass/fail.
        frame1(msg, 16'h29B1);
        frame8(msg, 16'h29B1, 1'b0);
        frame8(msg_good, 16'h0000, 1'b1);
        frame8(msg_bad, model_crc(msg_bad), 1'b0);

        // Nibble-wide append with three stalled cycles; enable ignored meanwhile.
        bus4.tx_ready = 1'b0;
        frame4_beats(msg, 1'b1);
        sb_tx.push_back(4'h2); sb_tx.push_back(4'h9); sb_tx.push_back(4'hB); sb_tx.push_back(4'h1);
        sb4.push_back({16'h29B1, 1'b0});
        @(posedge clk); #2;
        bus4.last = 1'b0; bus4.append = 1'b0; bus4.data_in = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_tx_valid", 32'(bus4.tx_valid), 32'd1);
            check("stall_tx_data", 32'(bus4.tx_data), 32'h2);
            check("stall_in_ready", 32'(bus4.in_ready), 32'd0);
            check("stall_crc_hold", 32'(bus4.crc_out), 32'h29B1);
        end
        @(posedge clk); #2;
        bus4.enable = 1'b0; bus4.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("slice_tx_valid", 32'(bus4.tx_valid), 32'd1);
            check("slice_in_ready", 32'(bus4.in_ready), 32'd0);
        end
        @(negedge clk);
        check("append_valid_after_slice", 32'(bus4.crc_valid), 32'd1);
        check("append_tx_dropped", 32'(bus4.tx_valid), 32'd0);
        @(negedge clk);
        check("append_valid_pulse", 32'(bus4.crc_valid), 32'd0);

        // init mid-frame together with a beat: beat dropped, register restarted.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            bus8.enable = 1'b1; bus8.data_in = msg[k]; bus8.last = 1'b0;
        end
        @(posedge clk); #2;
        bus8.init = 1'b1; bus8.data_in = 8'h35;
        @(posedge clk); #2;
        bus8.init = 1'b0; bus8.enable = 1'b0;
        @(negedge clk);
        check("init_crc_restart", 32'(bus8.crc_out), 32'hFFFF);
        check("init_in_ready", 32'(bus8.in_ready), 32'd1);
        frame8(msg, 16'h29B1, 1'b0);

        // init during APPEND aborts the append.
        bus4.tx_ready = 1'b0;
        frame4_beats(msg, 1'b1);
        end_beat4();
        @(negedge clk);
        check("pre_init_tx_valid", 32'(bus4.tx_valid), 32'd1);
        @(posedge clk); #2 bus4.init = 1'b1;
        @(posedge clk); #2 bus4.init = 1'b0;
        @(negedge clk);
        check("init_append_tx_valid", 32'(bus4.tx_valid), 32'd0);
        check("init_append_in_ready", 32'(bus4.in_ready), 32'd1);
        check("init_append_crc_out", 32'(bus4.crc_out), 32'hFFFF);
        @(negedge clk);
        check("init_append_no_valid", 32'(bus4.crc_valid), 32'd0);

        // Asynchronous reset between edges in the middle of APPEND.
        frame4_beats(msg, 1'b1);
        end_beat4();
        @(negedge clk);
        check("pre_rst_tx_valid", 32'(bus4.tx_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_tx_valid", 32'(bus4.tx_valid), 32'd0);
        check("arst_tx_data", 32'(bus4.tx_data), 32'd0);
        check("arst_in_ready", 32'(bus4.in_ready), 32'd1);
        check("arst_crc_out", 32'(bus4.crc_out), 32'hFFFF);
        @(negedge clk);
        #1 reset = 1'b1;
        bus4.tx_ready = 1'b1;
        frame4_beats(msg, 1'b0);
        sb4.push_back({16'h29B1, 1'b0});
        end_beat4();
        @(negedge clk);
        check("post_rst_valid", 32'(bus4.crc_valid), 32'd1);
        check("post_rst_no_tx", 32'(bus4.tx_valid), 32'd0);
        @(negedge clk);

        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb8_drained", 32'(sb8.size()), 32'd0);
        check("sb4_drained", 32'(sb4.size()), 32'd0);
        check("sb_tx_drained", 32'(sb_tx.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
